// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Handshake/operand bundle between the ALU control (master) and the
// bit-serial subtractor (slave).
//
// Signals (named from the subtractor's point of view):
//   i_start  request, sampled by the subtractor only when not busy
//   i_a      minuend      [WIDTH]
//   i_b      subtrahend   [WIDTH]
//   i_bin    borrow-in
//   o_busy   bits are being processed
//   o_done   one-cycle result-valid pulse
//   o_diff   difference   [WIDTH], held until the next DONE
//   o_bout   borrow-out of the MSB (unsigned A < B+BIN)
//   o_ovf    signed overflow
//   o_zero   difference is zero
//   o_lt/o_eq/o_gt  unsigned compare of A vs B+BIN
//                   (present only with SERIAL_SUB_CMP_EN defined)
//
// Configuration macro: SERIAL_SUB_CMP_EN
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_bin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_bout;
  logic             o_ovf;
  logic             o_zero;
`ifdef SERIAL_SUB_CMP_EN
  logic             o_lt;
  logic             o_eq;
  logic             o_gt;

  modport master (
    output i_start, i_a, i_b, i_bin,
    input  o_busy, o_done, o_diff, o_bout, o_ovf, o_zero, o_lt, o_eq, o_gt
  );

  modport slave (
    input  i_start, i_a, i_b, i_bin,
    output o_busy, o_done, o_diff, o_bout, o_ovf, o_zero, o_lt, o_eq, o_gt
  );
`else
  modport master (
    output i_start, i_a, i_b, i_bin,
    input  o_busy, o_done, o_diff, o_bout, o_ovf, o_zero
  );

  modport slave (
    input  i_start, i_a, i_b, i_bin,
    output o_busy, o_done, o_diff, o_bout, o_ovf, o_zero
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - BIN, one bit per clock,
// LSB first, using a single full-subtractor cell and a borrow flop.
// START/BUSY/DONE handshake; result flags are registered at DONE entry and
// held until the next DONE.
//
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  asynchronous reset, active-high
//   bus    serial_subtractor_if.slave (operands, handshake, result, flags)
//
// Parameter WIDTH must match the WIDTH of the connected interface.
// Configuration macro: SERIAL_SUB_CMP_EN adds registered LT/EQ/GT outputs.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for START
// S_SHIFT | processing one bit per clock (BUSY=1)
// S_DONE  | one-cycle result-valid pulse; START here restarts
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  // r_a doubles as the result shift register: each processed bit of A
  // leaves at the LSB while the difference bit enters at the MSB, so after
  // WIDTH shifts it holds the whole difference.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  // operand sign bits are shifted out of r_a/r_b, so keep them for OVF
  logic             r_a_msb;
  logic             r_b_msb;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_diff;
  logic             w_zero;

  assign w_a       = r_a[0];
  assign w_b       = r_b[0];
  assign w_d       = w_a ^ w_b ^ r_br;
  assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_accept  = bus.i_start && (r_state != S_SHIFT);
  assign w_diff    = {w_d, r_a[WIDTH-1:1]};
  assign w_zero    = ~|w_diff;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_br    <= bus.i_bin;
            r_cnt   <= '0;
            r_a_msb <= bus.i_a[WIDTH-1];
            r_b_msb <= bus.i_b[WIDTH-1];
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a   <= w_diff;
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result registers load only on the edge that processes the MSB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_diff <= w_diff;
      r_bout <= w_br_next;
      r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      r_zero <= w_zero;
    end
  end

  assign bus.o_busy = (r_state == S_SHIFT);
  assign bus.o_done = (r_state == S_DONE);
  assign bus.o_diff = r_diff;
  assign bus.o_bout = r_bout;
  assign bus.o_ovf  = r_ovf;
  assign bus.o_zero = r_zero;

`ifdef SERIAL_SUB_CMP_EN
  logic r_lt;
  logic r_eq;
  logic r_gt;

  // DIFF==0 with a borrow (A=0, B=all ones, BIN=1) is still "less than".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lt <= 1'b0;
      r_eq <= 1'b0;
      r_gt <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_lt <= w_br_next;
      r_eq <= w_zero & ~w_br_next;
      r_gt <= ~w_br_next & ~w_zero;
    end
  end

  assign bus.o_lt = r_lt;
  assign bus.o_eq = r_eq;
  assign bus.o_gt = r_gt;
`endif

endmodule
